// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU.
//   alu_op_e - 5-bit operation select (ALU_ADD=0 .. ALU_TEST=16; 17-31 unused)
//   FLAG_*   - bit positions inside the Z80-layout status byte
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_CP   = 5'd5,
    ALU_SLL  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SLA  = 5'd8,
    ALU_SRA  = 5'd9,
    ALU_ROL  = 5'd10,
    ALU_ROR  = 5'd11,
    ALU_INC  = 5'd12,
    ALU_DEC  = 5'd13,
    ALU_SET  = 5'd14,
    ALU_RES  = 5'd15,
    ALU_TEST = 5'd16
  } alu_op_e;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_H  = 4;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational shift/rotate unit for opcodes 6-11.
//   a      - value to shift or rotate
//   b      - unsigned amount (shifts saturate at alu_width, rotates use b mod alu_width)
//   op     - opcode; anything outside 6-11 yields zero
//   result - shifted/rotated value
//   carry  - last bit shifted out (rotates: the bit that wrapped); 0 when b == 0
module alu_shifter
  import alu_pkg::*;
#(
  parameter int alu_width = 8
) (
  input  logic [alu_width-1:0] a,
  input  logic [alu_width-1:0] b,
  input  logic [4:0]           op,
  output logic [alu_width-1:0] result,
  output logic                 carry
);

  localparam logic [alu_width-1:0] width_c = alu_width'(alu_width);

  // One guard bit beside the operand catches the last bit shifted out;
  // oversized amounts naturally push zeros (or sign bits) into it.
  logic [alu_width:0]     sll_ext_s;
  logic [alu_width:0]     srl_ext_s;
  logic [alu_width:0]     sra_ext_s;
  logic [alu_width-1:0]   rot_amt_s;
  logic [2*alu_width-1:0] rol_ext_s;
  logic [2*alu_width-1:0] ror_ext_s;
  logic                   amt_nz_s;

  assign sll_ext_s = {1'b0, a} << b;
  assign srl_ext_s = {a, 1'b0} >> b;
  assign sra_ext_s = $signed({a, 1'b0}) >>> b;
  assign rot_amt_s = b % width_c;
  // Rotating a doubled copy leaves the rotated word in one half.
  assign rol_ext_s = {a, a} << rot_amt_s;
  assign ror_ext_s = {a, a} >> rot_amt_s;
  assign amt_nz_s  = (b != {alu_width{1'b0}});

  // Select result and carry for the requested shift/rotate.
  always_comb begin
    result = {alu_width{1'b0}};
    carry  = 1'b0;
    case (op)
      ALU_SLL, ALU_SLA: begin
        result = sll_ext_s[alu_width-1:0];
        carry  = sll_ext_s[alu_width];
      end
      ALU_SRL: begin
        result = srl_ext_s[alu_width:1];
        carry  = srl_ext_s[0];
      end
      ALU_SRA: begin
        result = sra_ext_s[alu_width:1];
        carry  = sra_ext_s[0];
      end
      ALU_ROL: begin
        result = rol_ext_s[2*alu_width-1:alu_width];
        carry  = amt_nz_s ? rol_ext_s[alu_width] : 1'b0;
      end
      ALU_ROR: begin
        result = ror_ext_s[alu_width-1:0];
        carry  = amt_nz_s ? ror_ext_s[alu_width-1] : 1'b0;
      end
      default: begin
        result = {alu_width{1'b0}};
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: combinational ALU with a registered Z80-layout status byte.
//   clk         - rising-edge clock for the flag register
//   rst         - synchronous active-high reset; clears status_flag only
//   a, b        - operands (b is the amount for shifts/rotates)
//   opcode      - operation select, see alu_pkg::alu_op_e
//   out         - combinational result
//   status_flag - flags of the previous cycle: S Z 0 H 0 P/V N C
module alu
  import alu_pkg::*;
#(
  parameter int alu_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [alu_width-1:0] a,
  input  logic [alu_width-1:0] b,
  input  logic [4:0]           opcode,
  output logic [alu_width-1:0] out,
  output logic [7:0]           status_flag
);

  localparam int msb = alu_width - 1;
  localparam logic [alu_width:0] one_c = {{alu_width{1'b0}}, 1'b1};

  // 1 when the number of ones in v is even.
  function automatic logic even_parity(input logic [alu_width-1:0] v);
    return ~(^v);
  endfunction

  // Assemble a status byte; S and Z come from res, bits 5 and 3 stay 0.
  function automatic logic [7:0] pack_flags(input logic [alu_width-1:0] res,
                                            input logic h, input logic pv,
                                            input logic n, input logic c);
    logic [7:0] f;
    f          = 8'h00;
    f[FLAG_S]  = res[msb];
    f[FLAG_Z]  = (res == {alu_width{1'b0}});
    f[FLAG_H]  = h;
    f[FLAG_PV] = pv;
    f[FLAG_N]  = n;
    f[FLAG_C]  = c;
    return f;
  endfunction

  logic [alu_width:0]   add_s, sub_s, inc_s, dec_s;
  logic [4:0]           add_lo_s, sub_lo_s, inc_lo_s, dec_lo_s;
  logic                 add_v_s, sub_v_s, inc_v_s, dec_v_s;
  logic [alu_width-1:0] shift_res_s;
  logic                 shift_c_s;
  logic [7:0]           flags_s;
  logic [7:0]           status_r;

  // Extra top bit holds carry (add) or borrow (subtract).
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};
  assign inc_s = {1'b0, a} + one_c;
  assign dec_s = {1'b0, a} - one_c;

  // Low-nibble copies expose the half carry / half borrow in bit 4.
  assign add_lo_s = {1'b0, a[3:0]} + {1'b0, b[3:0]};
  assign sub_lo_s = {1'b0, a[3:0]} - {1'b0, b[3:0]};
  assign inc_lo_s = {1'b0, a[3:0]} + 5'd1;
  assign dec_lo_s = {1'b0, a[3:0]} - 5'd1;

  assign add_v_s = (a[msb] == b[msb]) && (add_s[msb] != a[msb]);
  assign sub_v_s = (a[msb] != b[msb]) && (sub_s[msb] != a[msb]);
  assign inc_v_s = ~a[msb] & inc_s[msb];
  assign dec_v_s = a[msb] & ~dec_s[msb];

  alu_shifter #(.alu_width(alu_width)) u_shifter (
    .a      (a),
    .b      (b),
    .op     (opcode),
    .result (shift_res_s),
    .carry  (shift_c_s)
  );

  // Result and next-flag selection per opcode.
  always_comb begin
    out     = {alu_width{1'b0}};
    flags_s = 8'h00;
    case (opcode)
      ALU_ADD: begin
        out     = add_s[msb:0];
        flags_s = pack_flags(add_s[msb:0], add_lo_s[4], add_v_s, 1'b0, add_s[alu_width]);
      end
      ALU_SUB: begin
        out     = sub_s[msb:0];
        flags_s = pack_flags(sub_s[msb:0], sub_lo_s[4], sub_v_s, 1'b1, sub_s[alu_width]);
      end
      ALU_CP: begin
        // Compare keeps a on the bus but flags the discarded difference.
        out     = a;
        flags_s = pack_flags(sub_s[msb:0], sub_lo_s[4], sub_v_s, 1'b1, sub_s[alu_width]);
      end
      ALU_AND: begin
        out     = a & b;
        flags_s = pack_flags(a & b, 1'b1, even_parity(a & b), 1'b0, 1'b0);
      end
      ALU_OR: begin
        out     = a | b;
        flags_s = pack_flags(a | b, 1'b0, even_parity(a | b), 1'b0, 1'b0);
      end
      ALU_XOR: begin
        out     = a ^ b;
        flags_s = pack_flags(a ^ b, 1'b0, even_parity(a ^ b), 1'b0, 1'b0);
      end
      ALU_SLL, ALU_SRL, ALU_SLA, ALU_SRA, ALU_ROL, ALU_ROR: begin
        out     = shift_res_s;
        flags_s = pack_flags(shift_res_s, 1'b0, even_parity(shift_res_s), 1'b0, shift_c_s);
      end
      ALU_INC: begin
        out     = inc_s[msb:0];
        flags_s = pack_flags(inc_s[msb:0], inc_lo_s[4], inc_v_s, 1'b0, status_r[FLAG_C]);
      end
      ALU_DEC: begin
        out     = dec_s[msb:0];
        flags_s = pack_flags(dec_s[msb:0], dec_lo_s[4], dec_v_s, 1'b1, status_r[FLAG_C]);
      end
      ALU_SET, ALU_RES, ALU_TEST: begin
        out     = {alu_width{1'b0}};
        flags_s = pack_flags({alu_width{1'b0}}, 1'b1, 1'b1, 1'b0, status_r[FLAG_C]);
      end
      default: begin
        out     = {alu_width{1'b0}};
        flags_s = 8'h00;
      end
    endcase
  end

  // Flag register: reset wins over the per-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r <= 8'h00;
    end else begin
      status_r <= flags_s;
    end
  end

  assign status_flag = status_r;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu (alu_width = 8).
module tb_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, out, status_flag;
  logic [4:0] opcode;

  int n_checks = 0;
  int n_fail   = 0;

  alu #(.alu_width(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .out         (out),
    .status_flag (status_flag)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Apply one vector: check out in the same cycle, flags (masked) after the edge.
  task automatic run_vec(input string tag, input logic [4:0] op, input logic [7:0] va,
                         input logic [7:0] vb, input logic [7:0] exp_out,
                         input logic [7:0] exp_flags, input logic [7:0] mask);
    @(negedge clk);
    opcode = op;
    a      = va;
    b      = vb;
    #1;
    check_value({tag, " out"}, out, exp_out);
    @(posedge clk);
    #1;
    check_value({tag, " flags"}, status_flag & mask, exp_flags & mask);
  endtask

  initial begin
    rst    = 1'b1;
    a      = 8'h00;
    b      = 8'h00;
    opcode = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset flags", status_flag, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Arithmetic
    run_vec("add ff+01", ALU_ADD, 8'hFF, 8'h01, 8'h00, 8'h51, 8'hFF);
    run_vec("add 70+47", ALU_ADD, 8'h70, 8'h47, 8'hB7, 8'h84, 8'hFF);
    run_vec("sub fe-ff", ALU_SUB, 8'hFE, 8'hFF, 8'hFF, 8'h93, 8'hFF);
    run_vec("sub 80-01", ALU_SUB, 8'h80, 8'h01, 8'h7F, 8'h16, 8'hFF);
    run_vec("sub 00-ff", ALU_SUB, 8'h00, 8'hFF, 8'h01, 8'h13, 8'hFF);
    run_vec("cp 05,07",  ALU_CP,  8'h05, 8'h07, 8'h05, 8'h93, 8'hFF);

    // INC/DEC keep C: preload C=1 with an ADD carry
    run_vec("add c=1",  ALU_ADD, 8'hFF, 8'h01, 8'h00, 8'h51, 8'hFF);
    run_vec("inc ff",   ALU_INC, 8'hFF, 8'h00, 8'h00, 8'h51, 8'hFF);
    run_vec("inc 7f",   ALU_INC, 8'h7F, 8'h00, 8'h80, 8'h95, 8'hFF);
    run_vec("dec 00",   ALU_DEC, 8'h00, 8'h00, 8'hFF, 8'h93, 8'hFF);
    run_vec("dec 80",   ALU_DEC, 8'h80, 8'h00, 8'h7F, 8'h17, 8'hFF);

    // Logic
    run_vec("and 0d,07", ALU_AND, 8'h0D, 8'h07, 8'h05, 8'h14, 8'hFE);
    run_vec("or cb,2b",  ALU_OR,  8'hCB, 8'h2B, 8'hEB, 8'h84, 8'hFE);
    run_vec("xor ff,8a", ALU_XOR, 8'hFF, 8'h8A, 8'h75, 8'h00, 8'hFE);
    run_vec("xor 07,07", ALU_XOR, 8'h07, 8'h07, 8'h00, 8'h44, 8'hFE);

    // Shifts
    run_vec("sll 0f<<6", ALU_SLL, 8'h0F, 8'd6, 8'hC0, 8'h85, 8'hFF);
    run_vec("sll 0f<<9", ALU_SLL, 8'h0F, 8'd9, 8'h00, 8'h44, 8'hFE);
    run_vec("sla 0f<<6", ALU_SLA, 8'h0F, 8'd6, 8'hC0, 8'h85, 8'hFF);
    run_vec("srl ca>>3", ALU_SRL, 8'hCA, 8'd3, 8'h19, 8'h00, 8'hFF);
    run_vec("srl ca>>8", ALU_SRL, 8'hCA, 8'd8, 8'h00, 8'h45, 8'hFF);
    run_vec("sra ca>>3", ALU_SRA, 8'hCA, 8'd3, 8'hF9, 8'h84, 8'hFF);
    run_vec("sra ca>>8", ALU_SRA, 8'hCA, 8'd8, 8'hFF, 8'h85, 8'hFF);
    run_vec("sra 4a>>8", ALU_SRA, 8'h4A, 8'd8, 8'h00, 8'h44, 8'hFF);

    // Rotates
    run_vec("rol ca,3",  ALU_ROL, 8'hCA, 8'd3,  8'h56, 8'h04, 8'hFF);
    run_vec("rol 80,10", ALU_ROL, 8'h80, 8'd10, 8'h02, 8'h00, 8'hFF);
    run_vec("ror ca,3",  ALU_ROR, 8'hCA, 8'd3,  8'h59, 8'h04, 8'hFF);
    run_vec("ror 80,10", ALU_ROR, 8'h80, 8'd10, 8'h20, 8'h00, 8'hFF);

    // Zero amount and parity
    run_vec("sll 02<<0", ALU_SLL, 8'h02, 8'd0, 8'h02, 8'h00, 8'hFF);
    run_vec("sll 03<<0", ALU_SLL, 8'h03, 8'd0, 8'h03, 8'h04, 8'hFF);

    // Reserved opcodes: C carried over (set it to 1 first)
    run_vec("srl c=1",   ALU_SRL,  8'hCA, 8'd8, 8'h00, 8'h45, 8'hFF);
    run_vec("set 7,7",   ALU_SET,  8'h07, 8'h07, 8'h00, 8'h55, 8'hFF);
    run_vec("res 7,7",   ALU_RES,  8'h07, 8'h07, 8'h00, 8'h55, 8'hFF);
    run_vec("test 7,7",  ALU_TEST, 8'h07, 8'h07, 8'h00, 8'h55, 8'hFF);
    run_vec("op20",      5'd20,    8'hFF, 8'h01, 8'h00, 8'h00, 8'hFF);

    // Reset clears flags but leaves out alone
    run_vec("add pre-rst", ALU_ADD, 8'hFF, 8'h01, 8'h00, 8'h51, 8'hFF);
    @(negedge clk);
    rst    = 1'b1;
    opcode = ALU_ADD;
    a      = 8'h12;
    b      = 8'h34;
    #1;
    check_value("rst out", out, 8'h46);
    @(posedge clk);
    #1;
    check_value("rst flags", status_flag, 8'h00);
    check_value("rst out after edge", out, 8'h46);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_value("post-rst flags", status_flag, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter alu_width, default 8: data width of a, b and out; all flag rules below are stated for alu_width and verified at 8.
REQ-002 clk  input  1: single clock, rising-edge active.
REQ-003 rst  input  1: synchronous, active-high reset.
REQ-004 a  input  alu_width: operand A; the shifted or rotated value for shift/rotate ops.
REQ-005 b  input  alu_width: operand B; the unsigned shift/rotate amount for shift/rotate ops.
REQ-006 opcode  input  5: operation select.
REQ-007 out  output  alu_width: combinational result.
REQ-008 status_flag  output  8: registered Z80-layout flags: bit7 S, bit6 Z, bit5 0, bit4 H, bit3 0, bit2 P/V, bit1 N, bit0 C.

Function
REQ-009 out SHALL be purely combinational from a, b and opcode, and valid in the same cycle, with no dependence on clk.
REQ-010 Opcodes 0-4: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR; all results truncated to alu_width.
REQ-011 Opcode 5 CP: out = a; flags exactly as for SUB.
REQ-012 Opcode 6 SLL: a << b; out = 0 when b >= alu_width.
REQ-013 Opcode 7 SRL: logical a >> b; out = 0 when b >= alu_width.
REQ-014 Opcode 8 SLA: identical result to SLL.
REQ-015 Opcode 9 SRA: arithmetic a >> b with sign fill; when b >= alu_width, out = all ones if a[msb]=1, else 0.
REQ-016 Opcode 10 ROL / opcode 11 ROR: rotate a left / right by (b mod alu_width).
REQ-017 Opcode 12 INC: out = a+1. Opcode 13 DEC: out = a-1.
REQ-018 Opcodes 14 SET, 15 RES, 16 TEST are reserved: out = 0.
REQ-019 Opcodes 17-31: out = 0; next flags all 0.
REQ-020 S = out[msb]; Z = (out == 0); bits 5 and 3 always 0.
REQ-021 ADD and INC: C = carry out of msb (INC leaves C at its registered value); H = carry out of bit 3; V = signed overflow (operands same sign, result sign differs); N = 0.
REQ-022 SUB, CP and DEC: C = borrow (a < b unsigned; DEC leaves C at its registered value); H = borrow from bit 4; V = signed overflow (operands differ in sign, result sign differs from a); N = 1.
REQ-023 AND: H = 1. OR, XOR and all shifts/rotates: H = 0. For all of these: P/V = even parity of out (1 when the number of ones is even); N = 0.
REQ-024 Shifts/rotates with amount > 0: C = last bit shifted out (ROL/ROR: the bit that wrapped). Amount = 0: C = 0, out = a.
REQ-025 Opcodes 14-16: flags S = 0, Z = 1, H = 1, P/V = 1, N = 0, C unchanged.
REQ-026 status_flag SHALL load the flags computed from the current inputs on every rising clk edge; latency 1 cycle after the inputs settle.

Reset
REQ-027 When rst = 1 at a rising clk edge, status_flag <= 8'h00.
REQ-028 rst SHALL NOT affect out.
REQ-029 rst has priority over a flag update in the same cycle.

Structure
REQ-030 A shared package alu_pkg SHALL hold the opcode enum (ALU_ADD=0 .. ALU_TEST=16) and the flag bit index constants (FLAG_S=7, FLAG_Z=6, FLAG_H=4, FLAG_PV=2, FLAG_N=1, FLAG_C=0).
REQ-031 One sub-module, alu_shifter, SHALL implement opcodes 6-11 and return the result and the carry-out bit.
REQ-032 All other logic SHALL be a single combinational case statement plus one flag register.

Verification
REQ-033 ADD a=8'hFF, b=8'h01 -> out 8'h00; next cycle Z=1, C=1, H=1, V=0. ADD a=8'h70, b=8'h47 -> out 8'hB7, V=1, S=1.
REQ-034 SUB a=8'hFE, b=8'hFF -> out 8'hFF, C=1, N=1. SUB a=8'h80, b=8'h01 -> out 8'h7F, V=1. SUB a=8'h00, b=8'hFF -> out 8'h01, C=1.
REQ-035 Logic ops: AND 8'h0D,8'h07 -> 8'h05; OR 8'hCB,8'h2B -> 8'hEB; XOR 8'hFF,8'h8A -> 8'h75; XOR 7,7 -> 0 with Z=1, P/V=1.
REQ-036 Shifts: SLL 8'h0F by 6 -> 8'hC0 and by 9 -> 8'h00. SRL 8'hCA by 3 -> 8'h19 and by 8 -> 0. SRA 8'hCA by 3 -> 8'hF9 and by 8 -> 8'hFF. SRA 8'h4A by 8 -> 8'h00.
REQ-037 Rotates: ROL 8'hCA by 3 -> 8'h56; ROL 8'h80 by 10 -> 8'h02; ROR 8'hCA by 3 -> 8'h59; ROR 8'h80 by 10 -> 8'h20.
REQ-038 Parity: SLL 8'h02 by 0 -> P/V=0; SLL 8'h03 by 0 -> P/V=1. SET/RES/TEST with 7,7 -> out 0. Asserting rst -> status_flag 8'h00 on the next edge, out unaffected.
